// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Purpose  : Bridges 32-bit word loads/stores from the MEM stage onto a
//            16-bit asynchronous SRAM as two consecutive halfword accesses
//            (low half first, then high half). While an access is in flight
//            `ready` is low so the pipeline freezes.
// Ports    : clk, rst (async, active-low)
//            rd_en, wr_en, address[31:0], write_data[31:0]  - MEM stage request
//            read_data[31:0] (registered), ready             - MEM stage response
//            SRAM_DQ[15:0] (inout), SRAM_ADDR[17:0], SRAM_WE_N, SRAM_OE_N,
//            SRAM_CE_N, SRAM_UB_N, SRAM_LB_N                 - SRAM pins
// Revision : 1.0 - initial release
// ============================================================================
module sram_controller #(
    parameter logic [31:0] BASE_ADDR  = 32'd1024,
    parameter int unsigned ACC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int unsigned      CNT_W        = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_reload = CNT_W'(ACC_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_write;
    logic [16:0]      r_word;
    logic [15:0]      r_lo;
    logic [31:0]      r_read_data;

    logic             w_req;
    logic             w_last;
    logic [16:0]      w_word;
    logic             w_ready;
    logic             w_we_n;
    logic             w_oe_n;
    logic             w_drive;
    logic             w_half;
    logic [15:0]      w_dq_out;

    assign w_req  = rd_en | wr_en;
    assign w_last = (r_cnt == '0);
    // Word index relative to the SRAM window; only 17 bits reach the pins.
    assign w_word = 17'((address - BASE_ADDR) >> 2);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and SRAM/pipeline control. All strobes are decoded from
    // the state register so an async reset drops WE_N and releases DQ
    // without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b1;
        w_we_n       = 1'b1;
        w_oe_n       = 1'b1;
        w_drive      = 1'b0;
        w_half       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = ~w_req;
                if (w_req) begin
                    w_next_state = ST_LOW;
                end
            end
            ST_LOW, ST_HIGH: begin
                w_ready = 1'b0;
                w_half  = (r_state == ST_HIGH);
                w_drive = r_is_write;
                w_oe_n  = r_is_write;
                // Write strobe released in the final cycle of each half so
                // data and address are held past the WE_N rising edge.
                w_we_n  = r_is_write ? w_last : 1'b1;
                if (w_last) begin
                    w_next_state = (r_state == ST_LOW) ? ST_HIGH : ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase counter, latched request and read data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_is_write  <= 1'b0;
            r_word      <= '0;
            r_lo        <= '0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_cnt      <= c_cnt_reload;
                        r_is_write <= wr_en;   // write wins if both asserted
                        r_word     <= w_word;
                    end
                end
                ST_LOW: begin
                    if (w_last) begin
                        r_cnt <= c_cnt_reload;
                        if (!r_is_write) begin
                            r_lo <= SRAM_DQ;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (w_last) begin
                        // High half is taken straight from the bus on the
                        // same edge the full word is published.
                        if (!r_is_write) begin
                            r_read_data <= {SRAM_DQ, r_lo};
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_dq_out  = w_half ? write_data[31:16] : write_data[15:0];
    assign SRAM_DQ   = w_drive ? w_dq_out : 16'bz;
    assign SRAM_ADDR = {r_word, w_half};
    assign SRAM_WE_N = w_we_n;
    assign SRAM_OE_N = w_oe_n;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign ready     = w_ready;
    assign read_data = r_read_data;

endmodule
`default_nettype wire
